// File: rtl/prng_share_ctrl.sv
// Round-robin arbiter that hands out words of one free-running PRNG, one grant per cycle,
// and sequences generator reseed (reset pulse, warm-up discard) periodically or on a bad word.
module prng_share_ctrl #(
  parameter int NUM_REQ       = 4,
  parameter int WIDTH         = 128,
  parameter int RESEED_PERIOD = 1024,
  parameter int RESEED_CYCLES = 2,
  parameter int WARMUP_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           prng_data,
  output logic                       gen_reset,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         ack,
  output logic [WIDTH-1:0]           rsp_data,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic                       ready,
  output logic                       stuck_err
);
  localparam int IDW    = $clog2(NUM_REQ);
  localparam int PH_MAX = (RESEED_CYCLES > WARMUP_CYCLES) ? RESEED_CYCLES : WARMUP_CYCLES;
  localparam int PW     = $clog2(PH_MAX + 1);
  localparam int CW     = $clog2(RESEED_PERIOD + 1);

  typedef enum logic [1:0] {RESEED, WARMUP, SERVE} state_t;

  state_t             state_q, state_d;
  logic [PW-1:0]      phase_q, phase_d;
  logic [CW-1:0]      word_cnt_q, word_cnt_d, word_inc;
  logic [IDW-1:0]     rr_q, rr_d;
  logic [WIDTH-1:0]   prev_q, prev_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic [IDW-1:0]     rsp_id_q, rsp_id_d;
  logic               stuck_q, stuck_d;

  logic [NUM_REQ-1:0] elig, rot;
  logic               found, bad_word;
  logic [IDW-1:0]     off, win, nxt;
  logic [IDW:0]       sum, sum_n;

  // Requester currently seeing its ack is masked so it can drop req without a double grant.
  always_comb begin
    elig  = req & ~ack_q;
    rot   = NUM_REQ'({elig, elig} >> rr_q);
    found = 1'b0;
    off   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        off   = IDW'(i);
      end
    end
    sum = {1'b0, rr_q} + {1'b0, off};
    if (sum >= (IDW+1)'(NUM_REQ)) sum = sum - (IDW+1)'(NUM_REQ);
    win   = sum[IDW-1:0];
    sum_n = {1'b0, win} + (IDW+1)'(1);
    if (sum_n >= (IDW+1)'(NUM_REQ)) sum_n = '0;
    nxt   = sum_n[IDW-1:0];
  end

  assign bad_word = (prng_data == '0) || (prng_data == prev_q);
  assign word_inc = word_cnt_q + CW'(1);

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    word_cnt_d = word_cnt_q;
    rr_d       = rr_q;
    prev_d     = prev_q;
    ack_d      = '0;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    stuck_d    = stuck_q;
    case (state_q)
      RESEED: begin
        if (phase_q == PW'(RESEED_CYCLES - 1)) begin
          state_d = WARMUP;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      WARMUP: begin
        prev_d = prng_data;
        if (phase_q == PW'(WARMUP_CYCLES - 1)) begin
          state_d = SERVE;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      SERVE: begin
        prev_d = prng_data;
        if (bad_word) begin
          stuck_d    = 1'b1;
          state_d    = RESEED;
          phase_d    = '0;
          word_cnt_d = '0;
        end else if (found) begin
          ack_d      = NUM_REQ'(1) << win;
          rsp_data_d = prng_data;
          rsp_id_d   = win;
          rr_d       = nxt;
          // The grant that completes the period is still delivered.
          if (word_inc == CW'(RESEED_PERIOD)) begin
            state_d    = RESEED;
            phase_d    = '0;
            word_cnt_d = '0;
          end else begin
            word_cnt_d = word_inc;
          end
        end
      end
      default: state_d = RESEED;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RESEED;
      phase_q    <= '0;
      word_cnt_q <= '0;
      rr_q       <= '0;
      prev_q     <= '0;
      ack_q      <= '0;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
      stuck_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      word_cnt_q <= word_cnt_d;
      rr_q       <= rr_d;
      prev_q     <= prev_d;
      ack_q      <= ack_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
      stuck_q    <= stuck_d;
    end
  end

  assign gen_reset = reset | (state_q == RESEED);
  assign ready     = (state_q == SERVE);
  assign ack       = ack_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign stuck_err = stuck_q;
endmodule

// File: tb/tb_prng_share_ctrl.sv
// Directed bench for prng_share_ctrl: reset/warm-up timing, round-robin order, ack masking,
// period reseed, stuck-word reseed and asynchronous reset with an ack outstanding.
module tb_prng_share_ctrl;
  logic         clk, reset;
  logic [127:0] prng_data;
  logic         gen_reset;
  logic [3:0]   req, ack;
  logic [127:0] rsp_data;
  logic [1:0]   rsp_id;
  logic         ready, stuck_err;

  logic [31:0]  gen_cnt;
  logic         force_zero;
  int           checks = 0;
  int           failures = 0;

  prng_share_ctrl #(
    .NUM_REQ(4), .WIDTH(128), .RESEED_PERIOD(8), .RESEED_CYCLES(2), .WARMUP_CYCLES(4)
  ) dut (
    .clk(clk), .reset(reset), .prng_data(prng_data), .gen_reset(gen_reset),
    .req(req), .ack(ack), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .ready(ready), .stuck_err(stuck_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Generator model: new non-zero word every cycle, restarts from its seed under gen_reset.
  always @(posedge clk) begin
    if (gen_reset) gen_cnt <= 32'd0;
    else           gen_cnt <= gen_cnt + 32'd1;
  end
  assign prng_data = force_zero ? 128'd0
                   : {gen_cnt, ~gen_cnt, 32'hDEADBEEF, gen_cnt ^ 32'h5A5A5A5A};

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [127:0] prev_word, last_rsp;
  logic [3:0]   exp_ack;
  logic [3:0]   one;
  logic         exp_gr, exp_rdy;

  initial begin
    one = 4'b0001;
    reset = 1'b1; req = '0; force_zero = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_gen_reset", gen_reset, 1);
    chk("rst_ack", ack, 0);
    chk("rst_ready", ready, 0);
    chk("rst_stuck", stuck_err, 0);
    chk("rst_id", rsp_id, 0);
    chk("rst_data", rsp_data, 0);

    // Release with all four requesting; period of 8 words forces a reseed mid-run.
    req = 4'b1111; reset = 1'b0;
    #1 chk("t1_gen_reset_k0", gen_reset, 1);
    prev_word = prng_data;
    last_rsp  = '0;
    for (int k = 1; k <= 21; k++) begin
      @(negedge clk);
      exp_gr  = (k == 1) || (k == 14) || (k == 15);
      exp_rdy = (k >= 6 && k <= 13) || (k >= 20);
      if (k >= 7 && k <= 14) exp_ack = one << ((k - 7) % 4);
      else if (k == 21)      exp_ack = 4'b0001;
      else                   exp_ack = 4'b0000;
      chk($sformatf("t2_gen_reset_k%0d", k), gen_reset, exp_gr);
      chk($sformatf("t2_ready_k%0d", k), ready, exp_rdy);
      chk($sformatf("t2_ack_k%0d", k), ack, exp_ack);
      if (exp_ack != 4'b0000) begin
        chk($sformatf("t2_id_k%0d", k), rsp_id, (k == 21) ? 0 : (k - 7) % 4);
        chk($sformatf("t2_data_k%0d", k), rsp_data, prev_word);
        chk($sformatf("t2_distinct_k%0d", k), rsp_data !== last_rsp, 1);
        last_rsp = rsp_data;
      end
      prev_word = prng_data;
    end

    // Single requester held high: served every other cycle.
    reset = 1'b1; req = '0;
    repeat (2) @(negedge clk);
    req = 4'b0100; reset = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      exp_ack = (k == 7 || k == 9 || k == 11) ? 4'b0100 : 4'b0000;
      chk($sformatf("t3_ack_k%0d", k), ack, exp_ack);
      if (exp_ack != 4'b0000) chk($sformatf("t3_id_k%0d", k), rsp_id, 2);
    end

    // Zero word while a grant is due: no ack, sticky error, reseed.
    force_zero = 1'b1;
    @(negedge clk);
    chk("t5_ack", ack, 0);
    chk("t5_stuck", stuck_err, 1);
    chk("t5_gen_reset", gen_reset, 1);
    chk("t5_ready", ready, 0);
    force_zero = 1'b0;
    for (int k = 14; k <= 20; k++) begin
      @(negedge clk);
      chk($sformatf("t5_gen_reset_k%0d", k), gen_reset, k == 14);
      chk($sformatf("t5_ready_k%0d", k), ready, k >= 19);
      chk($sformatf("t5_stuck_k%0d", k), stuck_err, 1);
      chk($sformatf("t5_ack_k%0d", k), ack, (k == 20) ? 4'b0100 : 4'b0000);
    end
    chk("t6_id_before", rsp_id, 2);

    // Asynchronous reset while the ack pulse is out.
    reset = 1'b1;
    #1;
    chk("t6_ack", ack, 0);
    chk("t6_id", rsp_id, 0);
    chk("t6_ready", ready, 0);
    chk("t6_gen_reset", gen_reset, 1);
    chk("t6_stuck", stuck_err, 0);
    @(negedge clk);
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
